ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Single-port RAM controller: clears every RAM entry after reset, then serves
// one read or write request at a time over a valid/ready handshake.
module ram_ctrl #(
  parameter int   ADDR_W     = 2,
  parameter logic INIT_VALUE = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_data,
  output logic              wr_done,
  output logic              init_done,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  inout  wire               ram_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] INIT_END = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WRITE,
    READ
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   initCnt_q;
  logic [ADDR_W:0]   initCnt_d;
  logic              ramWrite_q;
  logic [ADDR_W-1:0] ramAddr_q;
  logic              drive_q;
  logic              reqReady_q;
  logic              rspValid_q;
  logic              rspData_q;
  logic              wrDone_q;
  logic              initDone_q;

  assign initCnt_d = initCnt_q + 1'b1;

  // The write strobe doubles as the output enable, so drive and strobe cannot disagree.
  assign ram_data = ramWrite_q ? drive_q : 1'bz;

  assign req_ready   = reqReady_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_data    = rspData_q;
  assign wr_done     = wrDone_q;
  assign init_done   = initDone_q;
  assign ram_write   = ramWrite_q;
  assign ram_address = ramAddr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INIT;
      initCnt_q  <= '0;
      ramWrite_q <= 1'b0;
      ramAddr_q  <= '0;
      drive_q    <= 1'b0;
      reqReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= 1'b0;
      wrDone_q   <= 1'b0;
      initDone_q <= 1'b0;
    end else begin
      rspValid_q <= 1'b0;
      wrDone_q   <= 1'b0;
      case (state_q)
        INIT: begin
          // The extra counter bit marks that the last address has already been issued.
          if (initCnt_q == INIT_END) begin
            state_q    <= IDLE;
            ramWrite_q <= 1'b0;
            initDone_q <= 1'b1;
            reqReady_q <= 1'b1;
          end else begin
            ramWrite_q <= 1'b1;
            ramAddr_q  <= initCnt_q[ADDR_W-1:0];
            drive_q    <= INIT_VALUE;
            initCnt_q  <= initCnt_d;
          end
        end
        IDLE: begin
          if (req_valid && reqReady_q) begin
            reqReady_q <= 1'b0;
            ramAddr_q  <= req_addr;
            if (req_write) begin
              ramWrite_q <= 1'b1;
              drive_q    <= req_wdata;
              state_q    <= WRITE;
            end else begin
              ramWrite_q <= 1'b0;
              state_q    <= READ;
            end
          end
        end
        WRITE: begin
          ramWrite_q <= 1'b0;
          wrDone_q   <= 1'b1;
          reqReady_q <= 1'b1;
          state_q    <= IDLE;
        end
        READ: begin
          rspData_q  <= ram_data;
          rspValid_q <= 1'b1;
          reqReady_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q    <= INIT;
          ramWrite_q <= 1'b0;
          reqReady_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: a behavioural RAM sits on the shared data
// line, stimulus pushes expected responses, a monitor pops them on each pulse.
module tb_ram_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_write;
  logic [1:0] req_addr;
  logic       req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_data;
  logic       wr_done;
  logic       init_done;
  logic       ram_write;
  logic [1:0] ram_address;
  wire        ram_data;

  typedef struct {
    logic       isWrite;
    logic [1:0] addr;
    logic       data;
  } exp_t;

  exp_t sbQ[$];
  logic mem[0:3];
  logic expMem[0:3];
  int   checks = 0;
  int   fails = 0;

  ram_ctrl #(.ADDR_W(2), .INIT_VALUE(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .wr_done    (wr_done),
    .init_done  (init_done),
    .ram_write  (ram_write),
    .ram_address(ram_address),
    .ram_data   (ram_data)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: samples on the strobe, drives read data only when not strobed.
  always @(posedge clock) begin
    if (ram_write == 1'b1) mem[ram_address] <= ram_data;
  end
  assign ram_data = (ram_write == 1'b0) ? mem[ram_address] : 1'bz;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pops one expected response for every pulse the DUT presents.
  always @(negedge clock) begin
    if (rsp_valid === 1'b1 || wr_done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected pulse", {6'd0, rsp_valid, wr_done}, 8'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("pulse kind wr_done", 8'(wr_done), 8'(e.isWrite));
        checkOutput("pulse kind rsp_valid", 8'(rsp_valid), 8'(!e.isWrite));
        if (!e.isWrite) checkOutput("rsp_data", 8'(rsp_data), 8'(e.data));
      end
    end
  end

  task automatic checkResetState();
    checkOutput("reset ram_write", 8'(ram_write), 8'd0);
    checkOutput("reset ram_address", 8'(ram_address), 8'd0);
    checkOutput("reset req_ready", 8'(req_ready), 8'd0);
    checkOutput("reset rsp_valid", 8'(rsp_valid), 8'd0);
    checkOutput("reset wr_done", 8'(wr_done), 8'd0);
    checkOutput("reset init_done", 8'(init_done), 8'd0);
    checkOutput("reset rsp_data", 8'(rsp_data), 8'd0);
  endtask

  // Called at a negedge with reset just released; returns at the first IDLE negedge.
  task automatic checkInitSequence();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("init ram_write", 8'(ram_write), 8'd1);
      checkOutput("init ram_address", 8'(ram_address), 8'(i));
      checkOutput("init ram_data", 8'(ram_data), 8'd0);
      checkOutput("init req_ready", 8'(req_ready), 8'd0);
      checkOutput("init init_done", 8'(init_done), 8'd0);
      expMem[i] = 1'b0;
    end
    @(negedge clock);
    checkOutput("post-init init_done", 8'(init_done), 8'd1);
    checkOutput("post-init req_ready", 8'(req_ready), 8'd1);
    checkOutput("post-init ram_write", 8'(ram_write), 8'd0);
  endtask

  // Presents a request (valid stays high afterwards) and waits for acceptance.
  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic d,
                               input bit push, input int expWait);
    int waited;
    exp_t e;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    waited    = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      checkOutput("accept timeout", 8'(req_ready), 8'd1);
      return;
    end
    if (expWait >= 0) checkOutput("accept spacing", 8'(waited), 8'(expWait));
    if (push) begin
      e.isWrite = w;
      e.addr    = a;
      e.data    = w ? d : expMem[a];
      sbQ.push_back(e);
      if (w) expMem[a] = d;
    end
    @(posedge clock);
    @(negedge clock);
    checkOutput("busy req_ready", 8'(req_ready), 8'd0);
    checkOutput("op ram_write", 8'(ram_write), 8'(w));
    checkOutput("op ram_address", 8'(ram_address), 8'(a));
    if (w) checkOutput("op ram_data", 8'(ram_data), 8'(d));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 2'd0;
    req_wdata = 1'b0;
    repeat (2) @(negedge clock);
    checkResetState();
    reset = 1'b0;
    checkInitSequence();

    // Single write, then back-to-back alternating traffic with valid held high.
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b1, 0);
    req_valid = 1'b0;
    @(negedge clock);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 2'd1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b1, 1);
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("drained before reset", 8'(sbQ.size()), 8'd0);

    // Reset lands mid-READ: the read must vanish and INIT must replay.
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b0, 0);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clock);
    checkOutput("reset-in-read rsp_valid", 8'(rsp_valid), 8'd0);
    checkOutput("reset-in-read ram_write", 8'(ram_write), 8'd0);
    @(negedge clock);
    checkResetState();

    // A request held through INIT must wait for the first IDLE edge.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'd1;
    req_wdata = 1'b1;
    reset     = 1'b0;
    checkInitSequence();
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 2'd1, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("scoreboard drained", 8'(sbQ.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
